// File: rtl/adc_seq_sampler.sv
// ADC channel sequencer: on each divided sample tick, sweeps the enabled channels.
// For each channel it averages 2^AVG_LOG2 conversions and emits one result.
module adc_seq_sampler #(
  parameter int NUM_CH   = 4,
  parameter int CH_BASE  = 1,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int DIV_W    = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic              clear_flags,
  output logic              cmd_valid,
  output logic [4:0]        cmd_channel,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [4:0]        rsp_channel,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              out_valid,
  output logic [2:0]        out_channel,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  output logic              drop,
  output logic              mismatch
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int IDX_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, SCAN, CMD, WAIT_RSP, EMIT} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [NUM_CH-1:0] mask_r;
  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  rsp_cnt;
  logic              scan_hit;
  logic [IDX_W-1:0]  scan_idx;
  logic              out_free;

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] a);
    return a[ACC_W-1:AVG_LOG2];
  endfunction

  function automatic logic [4:0] ch_code(input logic [IDX_W-1:0] i);
    return 5'(CH_BASE) + {1'b0, i};
  endfunction

  // Sample-rate divider
  assign tick = enable && (div_cnt == rate_div);

  always_ff @(posedge sys_clk) begin
    if (reset || !enable || tick) div_cnt <= '0;
    else                          div_cnt <= div_cnt + DIV_W'(1);
  end

  // Lowest enabled channel at or above the current index, from the latched mask
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_r[i] && (IDX_W'(i) >= idx)) begin
        scan_hit = 1'b1;
        scan_idx = IDX_W'(i);
      end
    end
  end

  assign out_free = !out_valid || out_ready;
  assign busy     = (state != IDLE);

  // Sweep sequencer; flag sets are placed after the clear so a set wins
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      mask_r      <= '0;
      idx         <= '0;
      acc         <= '0;
      rsp_cnt     <= '0;
      cmd_valid   <= 1'b0;
      cmd_channel <= 5'(CH_BASE);
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_data    <= '0;
      overrun     <= 1'b0;
      drop        <= 1'b0;
      mismatch    <= 1'b0;
    end else begin
      if (clear_flags) begin
        overrun  <= 1'b0;
        drop     <= 1'b0;
        mismatch <= 1'b0;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (tick && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick && (ch_mask != '0)) begin
            mask_r <= ch_mask;
            idx    <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            idx         <= scan_idx;
            acc         <= '0;
            rsp_cnt     <= '0;
            cmd_valid   <= 1'b1;
            cmd_channel <= ch_code(scan_idx);
            state       <= CMD;
          end else begin
            state <= IDLE;
          end
        end
        CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_channel == cmd_channel) begin
              acc     <= acc + ACC_W'(rsp_data);
              rsp_cnt <= rsp_cnt + CNT_W'(1);
              if (rsp_cnt == LAST_CNT) begin
                state <= EMIT;
              end else begin
                cmd_valid <= 1'b1;
                state     <= CMD;
              end
            end else begin
              mismatch <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_free) begin
            out_valid   <= 1'b1;
            out_data    <= avg_trunc(acc);
            out_channel <= idx[2:0];
          end else begin
            drop <= 1'b1;
          end
          idx   <= idx + IDX_W'(1);
          state <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_seq_sampler.sv
// Bench for adc_seq_sampler: ADC responder plus averaging model feed a scoreboard
// that a separate monitor drains as results leave the block.
module tb_adc_seq_sampler;
  localparam int NUM_CH   = 4;
  localparam int CH_BASE  = 1;
  localparam int DATA_W   = 12;
  localparam int AVG_LOG2 = 2;
  localparam int DIV_W    = 16;
  localparam int NAVG     = 1 << AVG_LOG2;

  logic              sys_clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [DIV_W-1:0]  rate_div = '0;
  logic              clear_flags = 1'b0;
  logic              cmd_valid;
  logic [4:0]        cmd_channel;
  logic              cmd_ready = 1'b1;
  logic              rsp_valid = 1'b0;
  logic [4:0]        rsp_channel = '0;
  logic [DATA_W-1:0] rsp_data = '0;
  logic              out_valid;
  logic [2:0]        out_channel;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b1;
  logic              busy, overrun, drop, mismatch;

  adc_seq_sampler #(
    .NUM_CH(NUM_CH), .CH_BASE(CH_BASE), .DATA_W(DATA_W),
    .AVG_LOG2(AVG_LOG2), .DIV_W(DIV_W)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .enable(enable), .ch_mask(ch_mask),
    .rate_div(rate_div), .clear_flags(clear_flags),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_channel(out_channel), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .overrun(overrun), .drop(drop),
    .mismatch(mismatch)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { int ch; int data; } res_t;
  res_t exp_q[$];
  res_t out_log[$];
  res_t mon_e;
  int   cmd_log[$];

  int total = 0, bad = 0;
  int cmd_count = 0, out_count = 0;
  int rsp_delay = 1;
  bit sb_en = 1'b1, data_mode = 1'b0, bad_once = 1'b0, rsp_busy = 1'b0;
  int sums[NUM_CH];
  int cnts[NUM_CH];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic wait_busy(input bit lvl, input int lim, input string nm);
    int n = 0;
    while (busy !== lvl && n < lim) begin @(negedge sys_clk); n++; end
    if (busy !== lvl) begin
      total++; bad++;
      $display("FAIL %s: busy=%0d after %0d cycles, expected %0d", nm, busy, lim, lvl);
    end
  endtask

  task automatic wait_rsp_idle(input string nm);
    int n = 0;
    while (rsp_busy && n < 100) begin @(negedge sys_clk); n++; end
    if (rsp_busy) begin
      total++; bad++;
      $display("FAIL %s: responder still busy=1 expected 0", nm);
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1; step(1); clear_flags = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_cmd_valid"}, int'(cmd_valid), 0);
    check({tag, "_cmd_channel"}, int'(cmd_channel), CH_BASE);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_channel"}, int'(out_channel), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_flags"}, int'({overrun, drop, mismatch}), 0);
  endtask

  task automatic sweep(input logic [NUM_CH-1:0] m, input string nm);
    ch_mask = m; enable = 1'b1;
    wait_busy(1'b1, 40, {nm, "_start"});
    enable = 1'b0;
    wait_busy(1'b0, 400, {nm, "_end"});
    step(2);
  endtask

  // ADC model: answers each accepted command after rsp_delay cycles
  initial begin
    int c, d, k;
    foreach (sums[i]) begin sums[i] = 0; cnts[i] = 0; end
    forever begin
      @(negedge sys_clk);
      if (cmd_valid && cmd_ready && !reset) begin
        c = int'(cmd_channel);
        cmd_count++;
        cmd_log.push_back(c);
        rsp_busy = 1'b1;
        @(posedge sys_clk); #1;
        repeat (rsp_delay - 1) begin @(posedge sys_clk); #1; end
        if (bad_once) begin
          bad_once = 1'b0;
          rsp_valid = 1'b1; rsp_channel = 5'd7; rsp_data = '1;
          @(posedge sys_clk); #1;
          rsp_valid = 1'b0;
          @(negedge sys_clk);
          check("mismatch_set", int'(mismatch), 1);
          check("mismatch_stays_in_wait", int'(busy && !cmd_valid), 1);
          repeat (2) begin @(posedge sys_clk); #1; end
        end
        k = c - CH_BASE;
        d = data_mode ? 100 + cnts[k] : int'($urandom_range(0, (1 << DATA_W) - 1));
        rsp_valid = 1'b1; rsp_channel = 5'(c); rsp_data = DATA_W'(d);
        if (sb_en) begin
          sums[k] += d;
          cnts[k]++;
          if (cnts[k] == NAVG) begin
            exp_q.push_back('{ch: k, data: sums[k] / NAVG});
            sums[k] = 0;
            cnts[k] = 0;
          end
        end
        @(posedge sys_clk); #1;
        rsp_valid = 1'b0;
        rsp_busy = 1'b0;
      end
    end
  end

  // Monitor: compares every accepted result against the scoreboard
  initial begin
    forever begin
      @(negedge sys_clk);
      if (out_valid && out_ready && !reset) begin
        out_count++;
        out_log.push_back('{ch: int'(out_channel), data: int'(out_data)});
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: ch=%0d data=%0d, expected none", out_channel, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_channel", int'(out_channel), mon_e.ch);
          check("out_data", int'(out_data), mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_c, base_o, n, unstable, seen;
    logic [4:0] ch0;

    step(3);
    @(negedge sys_clk);
    chk_reset("rst");
    step(1); reset = 1'b0;

    // Two-channel sweep with known data; a later mask change must not matter
    data_mode = 1'b1; rsp_delay = 1; rate_div = 999;
    cmd_log.delete(); out_log.delete();
    ch_mask = 4'b0101; enable = 1'b1;
    wait_busy(1'b1, 1100, "t1_start");
    enable = 1'b0;
    step(1); ch_mask = 4'b1111;
    wait_busy(1'b0, 200, "t1_end");
    step(2);
    check("t1_out_count", out_log.size(), 2);
    if (out_log.size() >= 2) begin
      check("t1_o0_ch", out_log[0].ch, 0);
      check("t1_o0_data", out_log[0].data, 101);
      check("t1_o1_ch", out_log[1].ch, 2);
      check("t1_o1_data", out_log[1].data, 101);
    end
    check("t1_cmd_count", cmd_log.size(), 8);
    if (cmd_log.size() >= 8) begin
      check("t1_cmd_first", cmd_log[0], 1);
      check("t1_cmd_second", cmd_log[4], 3);
    end
    check("t1_drain", exp_q.size(), 0);
    data_mode = 1'b0;

    // Slow responses with a fast tick: overrun, no second sweep
    rate_div = 3; rsp_delay = 10; ch_mask = 4'b0001;
    base_c = cmd_count; base_o = out_count;
    enable = 1'b1;
    wait_busy(1'b1, 20, "t2_start");
    step(20); enable = 1'b0;
    wait_busy(1'b0, 300, "t2_end");
    step(2);
    check("t2_overrun", int'(overrun), 1);
    check("t2_cmds", cmd_count - base_c, NAVG);
    check("t2_outs", out_count - base_o, 1);
    check("t2_drain", exp_q.size(), 0);
    pulse_clear();
    check("t2_overrun_clr", int'(overrun), 0);

    // Back-pressure across two emits: first held, second dropped
    rate_div = 5; rsp_delay = 1; out_ready = 1'b0;
    ch_mask = 4'b0011; enable = 1'b1;
    wait_busy(1'b1, 20, "t3_start");
    enable = 1'b0;
    n = 0; unstable = 0; seen = 0;
    while (busy && n < 300) begin
      @(negedge sys_clk); n++;
      if (out_valid) begin
        seen++;
        if (exp_q.size() == 0 || int'(out_data) != exp_q[0].data || out_channel != 3'd0)
          unstable++;
      end
    end
    check("t3_held_valid", int'(out_valid), 1);
    check("t3_held_stable", unstable, 0);
    check("t3_drop", int'(drop), 1);
    check("t3_exp_pending", exp_q.size(), 2);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    step(1); out_ready = 1'b1;
    step(3);
    check("t3_drain", exp_q.size(), 0);
    pulse_clear();
    check("t3_drop_clr", int'(drop), 0);

    // Wrong response channel is discarded, then the sweep completes
    base_c = cmd_count; base_o = out_count;
    bad_once = 1'b1;
    sweep(4'b0001, "t4");
    check("t4_mismatch_sticky", int'(mismatch), 1);
    check("t4_cmds", cmd_count - base_c, NAVG);
    check("t4_outs", out_count - base_o, 1);
    check("t4_drain", exp_q.size(), 0);
    pulse_clear();
    check("t4_mismatch_clr", int'(mismatch), 0);

    // cmd_ready held low: command stays presented, accepted once
    base_c = cmd_count; base_o = out_count;
    cmd_ready = 1'b0; ch_mask = 4'b0001; enable = 1'b1;
    n = 0;
    while (!cmd_valid && n < 40) begin @(negedge sys_clk); n++; end
    enable = 1'b0;
    ch0 = cmd_channel;
    check("t5_cmd_channel", int'(ch0), CH_BASE);
    unstable = 0;
    repeat (5) begin
      @(negedge sys_clk);
      if (!(cmd_valid && cmd_channel == ch0)) unstable++;
    end
    check("t5_cmd_stable", unstable, 0);
    check("t5_none_accepted", cmd_count - base_c, 0);
    step(1); cmd_ready = 1'b1;
    step(1);
    @(negedge sys_clk);
    check("t5_one_accepted", cmd_count - base_c, 1);
    check("t5_cmd_dropped", int'(cmd_valid), 0);
    wait_busy(1'b0, 300, "t5_end");
    step(2);
    check("t5_outs", out_count - base_o, 1);
    check("t5_drain", exp_q.size(), 0);

    // Reset while waiting for a response; late response must be ignored
    sb_en = 1'b0; rsp_delay = 8; ch_mask = 4'b0001;
    base_c = cmd_count; base_o = out_count;
    enable = 1'b1;
    wait_busy(1'b1, 20, "t6_start");
    enable = 1'b0;
    n = 0;
    while (cmd_count == base_c && n < 40) begin @(negedge sys_clk); n++; end
    step(2);
    reset = 1'b1;
    step(1);
    @(negedge sys_clk);
    chk_reset("t6_rst");
    step(1); reset = 1'b0;
    wait_rsp_idle("t6_rsp");
    step(2);
    check("t6_late_ignored_busy", int'(busy), 0);
    check("t6_late_ignored_out", out_count - base_o, 0);
    sb_en = 1'b1; rsp_delay = 1;
    base_o = out_count;
    sweep(4'b1010, "t6_after");
    check("t6_after_outs", out_count - base_o, 2);
    check("t6_after_drain", exp_q.size(), 0);

    // Randomised sweeps against the averaging model
    rate_div = 7;
    for (int r = 0; r < 6; r++) begin
      logic [NUM_CH-1:0] m;
      m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      rsp_delay = int'($urandom_range(1, 4));
      base_o = out_count;
      sweep(m, "rnd");
      check("rnd_outs", out_count - base_o, $countones(m));
      check("rnd_drain", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
